intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
Parametrised multi-channel interrupt controller that replaces the single-input interrupter feeding g_interrupt into ex_stage. It accepts NCH external interrupt lines and supports per-channel enable, edge or level mode, priority, a global threshold, and claim/complete sequencing. Software reaches it through the dma I/O register port (io_we/io_wadr/io_radr word bus). The CPU sees one gated, registered g_interrupt.

Parameters:
NCH, 8, number of interrupt channels (1..24)
PRIO_W, 3, priority field width; priority 0 means never interrupt
BASE_ADR, 14'h3F00, word address [15:2] of register block (32 words)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-high (1 = reset)
irq_in  in  NCH  asynchronous interrupt lines
csr_meie  in  1  machine external interrupt enable from CSR
io_we  in  1  register write strobe
io_wadr  in  14  write word address [15:2]
io_wdata  in  32  write data
io_re  in  1  register read strobe
io_radr  in  14  read word address [15:2]
io_rdata  out  32  read data, valid cycle after io_re
g_interrupt  out  1  interrupt request to CPU
in_service  out  NCH  channels claimed and not yet completed

Behaviour:
- Register map, word offset from BASE_ADR: 0 ENABLE[NCH-1:0] RW; 1 MODE[NCH-1:0] RW (1=edge, 0=level); 2 PENDING RO for level bits, W1C for edge bits; 3 THRESHOLD[PRIO_W-1:0] RW; 4 CLAIM (read) / COMPLETE (write); 8+i PRIORITY of channel i, RW, [PRIO_W-1:0]. Unmapped or out-of-range reads return 0; writes ignored; unused bits read 0.
- Reset: all registers, synchronisers, pending, in_service, io_rdata and g_interrupt = 0.
- Input path: 2-flop synchroniser per line, then a 1-flop previous-value register for edge detection.
- Pending register per channel, updated each cycle. Level mode: pending <= synced level. Edge mode: set on synced 0->1, cleared by claim or W1C. Set has priority over a same-cycle clear.
- Pending latches regardless of ENABLE.
- Eligible[i] = pending & ENABLE & ~in_service & (PRIORITY[i] > THRESHOLD).
- Winner: highest priority among eligible; ties go to the lowest index. Combinational.
- g_interrupt <= csr_meie & |eligible (registered). Latency from irq_in rising to g_interrupt = 4 clk edges in both modes.
- Claim: io_re at offset 4. io_rdata <= winner index + 1, or 0 if none eligible. Same edge sets in_service[winner] and, in edge mode, clears pending[winner].
- Complete: io_we at offset 4 with io_wdata = id (1..NCH) clears in_service[id-1]. Id 0, id > NCH, or a channel not in service: no effect.
- Same-cycle claim read and complete write: claim uses the pre-complete state; both take effect.
- A level channel stays masked while in service. It re-asserts after complete if the line is still high.
- Mode change while pending: the pending bit is kept and follows the new-mode rules from the next cycle.
- Reset mid-claim: all state clears; io_rdata = 0 the following cycle.

Test Plan:
1. Reset, then read all offsets -> every io_rdata = 0; g_interrupt = 0.
2. ch2 edge, PRIORITY2=3, THRESHOLD=1, ENABLE=0x04, csr_meie=1; pulse irq_in[2] for 1 cycle -> g_interrupt = 1 exactly 4 edges later. Claim read returns 3; g_interrupt drops next cycle. Complete 3 -> in_service = 0.
3. ch1 and ch5 pending, both level-high, priorities 2 and 2 -> claim returns 2 (lowest index wins). Set PRIORITY5=4 -> next claim returns 6.
4. ch0 level high, prio 1, THRESHOLD=1 -> g_interrupt stays 0. THRESHOLD=0 -> g_interrupt = 1 after 1 cycle.
5. ch3 edge, pulse while disabled -> PENDING bit3 = 1 and g_interrupt = 0. Enable -> g_interrupt = 1. W1C 0x08 -> PENDING = 0 and g_interrupt drops.
6. Claim ch4 (edge), new edge arrives on the claim cycle -> pending stays 1. After complete, the next claim returns 5. Complete with id 0 and id 9 -> no state change.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl -- multi-channel interrupt controller feeding g_interrupt.
//
// Collects NCH asynchronous interrupt lines. Each line can be enabled,
// set to edge or level mode, and given a priority. A global threshold
// filters the lines, and claim/complete sequencing controls the
// in-service state. Software reaches the block through the word-addressed
// dma I/O register port. The CPU sees a single registered g_interrupt.
//
// Register map (word offset from BASE_ADR):
//   0      ENABLE     RW
//   1      MODE       RW  (1 = edge, 0 = level)
//   2      PENDING    RO for level bits, W1C for edge bits
//   3      THRESHOLD  RW
//   4      CLAIM on read, COMPLETE on write
//   8+i    PRIORITY of channel i, RW
//
// Ports:
//   clk          clock
//   rst_n        synchronous reset, active high (1 = reset)
//   irq_in       asynchronous interrupt lines
//   csr_meie     machine external interrupt enable
//   io_we        register write strobe
//   io_wadr      write word address [15:2]
//   io_wdata     write data
//   io_re        register read strobe
//   io_radr      read word address [15:2]
//   io_rdata     read data, valid the cycle after io_re
//   g_interrupt  interrupt request to the CPU
//   in_service   channels that are claimed and not yet completed

module intr_ctrl #(
   parameter int          NCH      = 8,
   parameter int          PRIO_W   = 3,
   parameter logic [13:0] BASE_ADR = 14'h3F00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    irq_in,
   input  logic              csr_meie,
   input  logic              io_we,
   input  logic [13:0]       io_wadr,
   input  logic [31:0]       io_wdata,
   input  logic              io_re,
   input  logic [13:0]       io_radr,
   output logic [31:0]       io_rdata,
   output logic              g_interrupt,
   output logic [NCH-1:0]    in_service
);

   logic [NCH-1:0]    sync1;
   logic [NCH-1:0]    sync2;
   logic [NCH-1:0]    prev;
   logic [NCH-1:0]    pending;
   logic [NCH-1:0]    enable;
   logic [NCH-1:0]    mode;
   logic [PRIO_W-1:0] threshold;
   logic [PRIO_W-1:0] prio [NCH];

   logic [13:0]       w_off;
   logic [13:0]       r_off;
   logic              w_hit;
   logic              r_hit;
   logic [4:0]        w_sel;
   logic [4:0]        r_sel;
   logic              claim;
   logic              complete;
   logic              w1c;

   logic [NCH-1:0]    rise;
   logic [NCH-1:0]    eligible;
   logic              win_valid;
   logic [4:0]        win_idx;
   logic [PRIO_W-1:0] win_prio;
   logic [NCH-1:0]    claim_mask;
   logic [NCH-1:0]    cmp_mask;
   logic [NCH-1:0]    pending_n;
   logic [31:0]       rd_val;

   // Offset-based decode tolerates a base that is not 32-word aligned.
   assign w_off    = io_wadr - BASE_ADR;
   assign r_off    = io_radr - BASE_ADR;
   assign w_hit    = io_we && (w_off < 14'd32);
   assign r_hit    = io_re && (r_off < 14'd32);
   assign w_sel    = w_off[4:0];
   assign r_sel    = r_off[4:0];
   assign claim    = r_hit && (r_sel == 5'd4);
   assign complete = w_hit && (w_sel == 5'd4);
   assign w1c      = w_hit && (w_sel == 5'd2);

   assign rise = sync2 & ~prev;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NCH; i++) begin
         eligible[i] = pending[i] & enable[i] & ~in_service[i] & (prio[i] > threshold);
      end
   end

   // Scan from the top index down with >= so that, among equal priorities,
   // the lowest index is the last one to win.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      win_prio  = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (eligible[i] && (prio[i] >= win_prio)) begin
            win_valid = 1'b1;
            win_idx   = 5'(i);
            win_prio  = prio[i];
         end
      end
   end

   always_comb begin
      claim_mask = '0;
      cmp_mask   = '0;
      for (int i = 0; i < NCH; i++) begin
         claim_mask[i] = claim & win_valid & (win_idx == 5'(i));
         cmp_mask[i]   = complete & (io_wdata == 32'(i + 1));
      end
   end

   // Edge bits: a new rising edge wins over a same-cycle claim or W1C clear.
   always_comb begin
      pending_n = '0;
      for (int i = 0; i < NCH; i++) begin
         if (mode[i]) begin
            pending_n[i] = rise[i] | (pending[i] & ~claim_mask[i] & ~(w1c & io_wdata[i]));
         end else begin
            pending_n[i] = sync2[i];
         end
      end
   end

   always_comb begin
      rd_val = '0;
      case (r_sel)
         5'd0: rd_val[NCH-1:0]    = enable;
         5'd1: rd_val[NCH-1:0]    = mode;
         5'd2: rd_val[NCH-1:0]    = pending;
         5'd3: rd_val[PRIO_W-1:0] = threshold;
         5'd4: rd_val[4:0]        = win_valid ? (win_idx + 5'd1) : 5'd0;
         default: begin
            for (int i = 0; i < NCH; i++) begin
               if (r_sel == 5'(8 + i)) begin
                  rd_val[PRIO_W-1:0] = prio[i];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         sync1       <= '0;
         sync2       <= '0;
         prev        <= '0;
         pending     <= '0;
         enable      <= '0;
         mode        <= '0;
         threshold   <= '0;
         in_service  <= '0;
         io_rdata    <= '0;
         g_interrupt <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            prio[i] <= '0;
         end
      end else begin
         sync1       <= irq_in;
         sync2       <= sync1;
         prev        <= sync2;
         pending     <= pending_n;
         g_interrupt <= csr_meie & (|eligible);
         io_rdata    <= r_hit ? rd_val : 32'd0;

         // The claimed winner is never in service, so set and clear cannot collide.
         in_service  <= (in_service & ~cmp_mask) | claim_mask;

         if (w_hit && (w_sel == 5'd0)) begin
            enable <= io_wdata[NCH-1:0];
         end
         if (w_hit && (w_sel == 5'd1)) begin
            mode <= io_wdata[NCH-1:0];
         end
         if (w_hit && (w_sel == 5'd3)) begin
            threshold <= io_wdata[PRIO_W-1:0];
         end
         for (int i = 0; i < NCH; i++) begin
            if (w_hit && (w_sel == 5'(8 + i))) begin
               prio[i] <= io_wdata[PRIO_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl -- directed bench for intr_ctrl with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.

module tb_intr_ctrl;

   localparam int          NCH  = 8;
   localparam logic [13:0] BASE = 14'h3F00;

   logic           clk;
   logic           rst_n;
   logic [NCH-1:0] irq_in;
   logic           csr_meie;
   logic           io_we;
   logic [13:0]    io_wadr;
   logic [31:0]    io_wdata;
   logic           io_re;
   logic [13:0]    io_radr;
   logic [31:0]    io_rdata;
   logic           g_interrupt;
   logic [NCH-1:0] in_service;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] rv;

   intr_ctrl #(.NCH(NCH), .PRIO_W(3), .BASE_ADR(BASE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_in      (irq_in),
      .csr_meie    (csr_meie),
      .io_we       (io_we),
      .io_wadr     (io_wadr),
      .io_wdata    (io_wdata),
      .io_re       (io_re),
      .io_radr     (io_radr),
      .io_rdata    (io_rdata),
      .g_interrupt (g_interrupt),
      .in_service  (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      io_we    = 1'b1;
      io_wadr  = BASE + 14'(off);
      io_wdata = d;
      tick();
      io_we    = 1'b0;
   endtask

   task automatic rd_adr(input logic [13:0] a, output logic [31:0] d);
      io_re   = 1'b1;
      io_radr = a;
      tick();
      io_re   = 1'b0;
      d       = io_rdata;
   endtask

   task automatic rd(input int off, output logic [31:0] d);
      rd_adr(BASE + 14'(off), d);
   endtask

   initial begin
      rst_n    = 1'b1;
      irq_in   = '0;
      csr_meie = 1'b0;
      io_we    = 1'b0;
      io_wadr  = '0;
      io_wdata = '0;
      io_re    = 1'b0;
      io_radr  = '0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();

      // 1: reset state
      for (int i = 0; i < 32; i++) begin
         rd(i, rv);
         check($sformatf("reset_rd%0d", i), rv, 32'd0);
      end
      check("reset_g", 32'(g_interrupt), 32'd0);
      check("reset_insvc", 32'(in_service), 32'd0);

      // 2: single edge channel, latency and claim/complete
      csr_meie = 1'b1;
      wr(8 + 2, 32'd3);
      wr(3, 32'd1);
      wr(1, 32'h04);
      wr(0, 32'h04);
      rd(3, rv);
      check("thr_rb", rv, 32'd1);
      rd(10, rv);
      check("prio2_rb", rv, 32'd3);
      irq_in[2] = 1'b1;
      tick();
      irq_in[2] = 1'b0;
      tick();
      tick();
      check("t2_g_edge3", 32'(g_interrupt), 32'd0);
      tick();
      check("t2_g_edge4", 32'(g_interrupt), 32'd1);
      rd(4, rv);
      check("t2_claim", rv, 32'd3);
      check("t2_insvc", 32'(in_service), 32'h04);
      tick();
      check("t2_g_drop", 32'(g_interrupt), 32'd0);
      rd(2, rv);
      check("t2_pend_clr", rv, 32'd0);
      wr(4, 32'd3);
      check("t2_complete", 32'(in_service), 32'd0);

      // 3: level channels, tie-break and priority
      wr(1, 32'h00);
      wr(8 + 1, 32'd2);
      wr(8 + 5, 32'd2);
      wr(0, 32'h22);
      irq_in[1] = 1'b1;
      irq_in[5] = 1'b1;
      repeat (4) tick();
      check("t3_g", 32'(g_interrupt), 32'd1);
      rd(4, rv);
      check("t3_claim_tie", rv, 32'd2);
      check("t3_insvc", 32'(in_service), 32'h02);
      wr(4, 32'd2);
      wr(8 + 5, 32'd4);
      rd(4, rv);
      check("t3_claim_prio", rv, 32'd6);
      wr(4, 32'd6);
      check("t3_insvc_clr", 32'(in_service), 32'd0);
      irq_in[1] = 1'b0;
      irq_in[5] = 1'b0;
      wr(0, 32'h00);
      repeat (3) tick();

      // 4: threshold boundary, meie gating, level re-assert after complete
      wr(8 + 0, 32'd1);
      wr(0, 32'h01);
      irq_in[0] = 1'b1;
      repeat (5) tick();
      check("t4_g_thr", 32'(g_interrupt), 32'd0);
      rd(2, rv);
      check("t4_pend_lvl", rv, 32'h01);
      wr(3, 32'd0);
      check("t4_g_same", 32'(g_interrupt), 32'd0);
      tick();
      check("t4_g_thr0", 32'(g_interrupt), 32'd1);
      csr_meie = 1'b0;
      tick();
      check("t4_meie_off", 32'(g_interrupt), 32'd0);
      csr_meie = 1'b1;
      tick();
      check("t4_meie_on", 32'(g_interrupt), 32'd1);
      rd(4, rv);
      check("t4_claim", rv, 32'd1);
      tick();
      check("t4_masked", 32'(g_interrupt), 32'd0);
      wr(4, 32'd1);
      tick();
      check("t4_reassert", 32'(g_interrupt), 32'd1);
      irq_in[0] = 1'b0;
      wr(0, 32'h00);
      wr(3, 32'd1);
      repeat (3) tick();

      // 5: pending latches while disabled; W1C clears edge bit
      wr(1, 32'h08);
      wr(8 + 3, 32'd5);
      irq_in[3] = 1'b1;
      tick();
      irq_in[3] = 1'b0;
      repeat (3) tick();
      rd(2, rv);
      check("t5_pend", rv, 32'h08);
      check("t5_g_dis", 32'(g_interrupt), 32'd0);
      wr(0, 32'h08);
      tick();
      check("t5_g_en", 32'(g_interrupt), 32'd1);
      wr(2, 32'h08);
      tick();
      check("t5_g_w1c", 32'(g_interrupt), 32'd0);
      rd(2, rv);
      check("t5_pend_w1c", rv, 32'd0);

      // 6: edge on claim cycle, bad complete ids
      wr(1, 32'h10);
      wr(8 + 4, 32'd4);
      wr(0, 32'h10);
      irq_in[4] = 1'b1;
      tick();
      irq_in[4] = 1'b0;
      repeat (3) tick();
      check("t6_g", 32'(g_interrupt), 32'd1);
      repeat (3) tick();
      irq_in[4] = 1'b1;
      tick();
      irq_in[4] = 1'b0;
      tick();
      rd(4, rv);
      check("t6_claim", rv, 32'd5);
      rd(2, rv);
      check("t6_pend_kept", rv, 32'h10);
      wr(4, 32'd0);
      check("t6_cmp_id0", 32'(in_service), 32'h10);
      wr(4, 32'd9);
      check("t6_cmp_id9", 32'(in_service), 32'h10);
      rd(2, rv);
      check("t6_pend_bad", rv, 32'h10);
      wr(4, 32'd5);
      check("t6_complete", 32'(in_service), 32'd0);
      rd(4, rv);
      check("t6_reclaim", rv, 32'd5);
      rd(2, rv);
      check("t6_pend_clr", rv, 32'd0);
      wr(4, 32'd5);

      // unmapped / out-of-range accesses
      wr(16, 32'h7);
      rd(16, rv);
      check("unm_prio8", rv, 32'd0);
      rd(5, rv);
      check("unm_off5", rv, 32'd0);
      rd_adr(BASE - 14'd1, rv);
      check("unm_below", rv, 32'd0);
      rd(12, rv);
      check("prio4_rb", rv, 32'd4);

      // reset during a claim read
      irq_in[4] = 1'b1;
      tick();
      irq_in[4] = 1'b0;
      repeat (4) tick();
      check("rst_pre_g", 32'(g_interrupt), 32'd1);
      io_re   = 1'b1;
      io_radr = BASE + 14'd4;
      rst_n   = 1'b1;
      tick();
      io_re = 1'b0;
      check("rst_rdata", io_rdata, 32'd0);
      check("rst_g", 32'(g_interrupt), 32'd0);
      check("rst_insvc", 32'(in_service), 32'd0);
      rst_n = 1'b0;
      rd(0, rv);
      check("rst_enable", rv, 32'd0);
      rd(2, rv);
      check("rst_pend", rv, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
